// File: rtl/axil_reg_pkg.sv
// Shared constants and types for the AXI4-Lite register responder.
package axil_reg_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        DEC_CTRL,
        DEC_STAT,
        DEC_NONE
    } dec_class_e;

    // Width of a register index able to address every decoded word.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axil_reg_responder_if.sv
// AXI4-Lite bus bundle; the master modport drives requests, the slave modport answers them.
interface axil_intfc #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BL = DATA_W / 8;

    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [BL-1:0]     wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axil_reg_decode.sv
// Combinational byte-address to word-index decoder, classifying the word as control, status or unmapped.
module axil_reg_decode
    import axil_reg_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int BL       = 4,
    parameter int NUM_CTRL = 4,
    parameter int NUM_STAT = 2,
    parameter int IDX_W    = 3
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [IDX_W-1:0]  idx,
    output dec_class_e        cls
);

    localparam int LSB = $clog2(BL);

    logic [ADDR_W-1:0] word;

    // The full word index is compared so aliases above the register window decode as unmapped.
    assign word = addr >> LSB;
    assign idx  = word[IDX_W-1:0];

    always_comb begin
        cls = DEC_NONE;
        if (word < ADDR_W'(NUM_CTRL)) begin
            cls = DEC_CTRL;
        end else if (word < ADDR_W'(NUM_CTRL + NUM_STAT)) begin
            cls = DEC_STAT;
        end
    end

endmodule

// File: rtl/axil_reg_responder.sv
// AXI4-Lite slave exposing writable control registers followed by read-only status words.
module axil_reg_responder
    import axil_reg_pkg::*;
#(
    parameter int IS_64_BIT      = 0,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int NUM_CTRL       = 4,
    parameter int NUM_STAT       = 2,
    localparam int DW            = (IS_64_BIT != 0) ? 64 : 32,
    localparam int BL            = DW / 8,
    localparam int STAT_W        = ((NUM_STAT > 0) ? NUM_STAT : 1) * DW
) (
    input  logic                   aclk,
    input  logic                   areset,
    axil_intfc.slave               bus,
    output logic [NUM_CTRL*DW-1:0] ctrl_regs,
    output logic [NUM_CTRL-1:0]    ctrl_wr_pulse,
    input  logic [STAT_W-1:0]      stat_in
);

    localparam int IDX_W = idx_width(NUM_CTRL + NUM_STAT);

    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic                      aw_held;
    logic [DW-1:0]             w_data;
    logic [BL-1:0]             w_strb;
    logic                      w_held;
    logic                      bvalid;
    logic [1:0]                bresp;
    logic                      rvalid;
    logic [1:0]                rresp;
    logic [DW-1:0]             rdata;
    logic [DW-1:0]             ctrl_q [NUM_CTRL];
    logic [NUM_CTRL-1:0]       pulse;

    logic                      awready;
    logic                      wready;
    logic                      arready;
    logic                      aw_fire;
    logic                      w_fire;
    logic                      ar_fire;
    logic                      commit;
    logic [IDX_W-1:0]          widx;
    logic [IDX_W-1:0]          ridx;
    dec_class_e                wcls;
    dec_class_e                rcls;
    logic [DW-1:0]             rd_word;

    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] cur,
                                                  input logic [DW-1:0] nxt,
                                                  input logic [BL-1:0] strb);
        logic [DW-1:0] r;
        r = cur;
        for (int k = 0; k < BL; k++) begin
            if (strb[k]) r[k*8 +: 8] = nxt[k*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [1:0] write_resp(input dec_class_e c);
        case (c)
            DEC_CTRL: return RESP_OKAY;
            DEC_STAT: return RESP_SLVERR;
            default:  return RESP_DECERR;
        endcase
    endfunction

    axil_reg_decode #(
        .ADDR_W  (AXI_ADDR_WIDTH),
        .BL      (BL),
        .NUM_CTRL(NUM_CTRL),
        .NUM_STAT(NUM_STAT),
        .IDX_W   (IDX_W)
    ) u_wdec (
        .addr(aw_addr),
        .idx (widx),
        .cls (wcls)
    );

    axil_reg_decode #(
        .ADDR_W  (AXI_ADDR_WIDTH),
        .BL      (BL),
        .NUM_CTRL(NUM_CTRL),
        .NUM_STAT(NUM_STAT),
        .IDX_W   (IDX_W)
    ) u_rdec (
        .addr(bus.araddr),
        .idx (ridx),
        .cls (rcls)
    );

    // Ready depends only on held state, never on the master's valids.
    assign awready = !areset && !aw_held && !bvalid;
    assign wready  = !areset && !w_held && !bvalid;
    assign arready = !areset && !rvalid;
    assign aw_fire = bus.awvalid && awready;
    assign w_fire  = bus.wvalid && wready;
    assign ar_fire = bus.arvalid && arready;
    assign commit  = aw_held && w_held && !bvalid;

    always_ff @(posedge aclk) begin
        if (aw_fire) aw_addr <= bus.awaddr;
        if (w_fire) begin
            w_data <= bus.wdata;
            w_strb <= bus.wstrb;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
            pulse   <= '0;
            for (int i = 0; i < NUM_CTRL; i++) ctrl_q[i] <= '0;
        end else begin
            pulse <= '0;
            if (aw_fire) aw_held <= 1'b1;
            if (w_fire)  w_held  <= 1'b1;
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= write_resp(wcls);
                if (wcls == DEC_CTRL) begin
                    for (int i = 0; i < NUM_CTRL; i++) begin
                        if (widx == IDX_W'(i)) begin
                            ctrl_q[i] <= merge_bytes(ctrl_q[i], w_data, w_strb);
                            pulse[i]  <= 1'b1;
                        end
                    end
                end
            end else if (bvalid && bus.bready) begin
                bvalid <= 1'b0;
            end
        end
    end

    // Control words are read before any same-edge commit lands; status is sampled live.
    always_comb begin
        rd_word = '0;
        if (rcls == DEC_CTRL) begin
            for (int i = 0; i < NUM_CTRL; i++) begin
                if (ridx == IDX_W'(i)) rd_word = ctrl_q[i];
            end
        end else if (rcls == DEC_STAT) begin
            for (int j = 0; j < NUM_STAT; j++) begin
                if (ridx == IDX_W'(NUM_CTRL + j)) rd_word = stat_in[j*DW +: DW];
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            rvalid <= 1'b0;
            rresp  <= RESP_OKAY;
            rdata  <= '0;
        end else if (ar_fire) begin
            rvalid <= 1'b1;
            rdata  <= rd_word;
            rresp  <= (rcls == DEC_NONE) ? RESP_DECERR : RESP_OKAY;
        end else if (rvalid && bus.rready) begin
            rvalid <= 1'b0;
        end
    end

    for (genvar g = 0; g < NUM_CTRL; g++) begin : g_ctrl_out
        assign ctrl_regs[g*DW +: DW] = ctrl_q[g];
    end

    assign ctrl_wr_pulse = pulse;
    assign bus.awready   = awready;
    assign bus.wready    = wready;
    assign bus.bvalid    = bvalid;
    assign bus.bresp     = bresp;
    assign bus.arready   = arready;
    assign bus.rvalid    = rvalid;
    assign bus.rresp     = rresp;
    assign bus.rdata     = rdata;

endmodule

// File: tb/tb_axil_reg_responder.sv
// Randomized and directed bench for axil_reg_responder against an array-based register model.
module tb_axil_reg_responder;

    logic         clk;
    logic         rst;
    logic [127:0] ctrl_regs;
    logic [3:0]   pulse;
    logic [63:0]  stat_in;

    logic [31:0]  model [4];
    int           vectors;
    int           miscompares;

    axil_intfc #(.ADDR_W(32), .DATA_W(32)) bus ();

    axil_reg_responder #(
        .IS_64_BIT     (0),
        .AXI_ADDR_WIDTH(32),
        .NUM_CTRL      (4),
        .NUM_STAT      (2)
    ) dut (
        .aclk         (clk),
        .areset       (rst),
        .bus          (bus),
        .ctrl_regs    (ctrl_regs),
        .ctrl_wr_pulse(pulse),
        .stat_in      (stat_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // 0 = control, 1 = status, 2 = unmapped
    function automatic int classify(input logic [31:0] addr);
        logic [31:0] w;
        w = addr >> 2;
        if (w < 4) return 0;
        if (w < 6) return 1;
        return 2;
    endfunction

    function automatic logic [127:0] model_flat();
        return {model[3], model[2], model[1], model[0]};
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        int c;
        int idx;
        c = classify(addr);
        idx = int'(addr >> 2);
        if (c == 0) return model[idx];
        if (c == 1) return (idx == 4) ? stat_in[31:0] : stat_in[63:32];
        return 32'h0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) model[i] = 32'h0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_off, input int w_off, input int bdelay);
        int cyc;
        bit aw_done, w_done, aw_f, w_f;
        int c;
        int idx;
        logic [1:0] exp_resp;
        logic [3:0] exp_pulse;
        c = classify(addr);
        idx = int'(addr >> 2);
        exp_resp = (c == 0) ? 2'b00 : (c == 1) ? 2'b10 : 2'b11;
        exp_pulse = (c == 0) ? 4'(1 << idx) : 4'h0;
        cyc = 0;
        aw_done = 0;
        w_done = 0;
        while (!(aw_done && w_done)) begin
            @(negedge clk);
            if (cyc > 40) begin
                check_eq("wr_handshake_timeout", 1, 0);
                break;
            end
            bus.awvalid = !aw_done && (cyc >= aw_off);
            bus.awaddr  = addr;
            bus.wvalid  = !w_done && (cyc >= w_off);
            bus.wdata   = data;
            bus.wstrb   = strb;
            aw_f = bus.awvalid && bus.awready;
            w_f  = bus.wvalid && bus.wready;
            @(posedge clk);
            aw_done |= aw_f;
            w_done  |= w_f;
            cyc++;
        end
        @(negedge clk);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        check_eq("wr_bvalid_early", bus.bvalid, 0);
        check_eq("wr_ready_held", {bus.awready, bus.wready}, 2'b00);
        @(negedge clk);
        if (c == 0) begin
            for (int b = 0; b < 4; b++) if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
        end
        check_eq("wr_bvalid", bus.bvalid, 1);
        check_eq("wr_bresp", bus.bresp, exp_resp);
        check_eq("wr_pulse", pulse, exp_pulse);
        check_eq("wr_ctrl_regs", ctrl_regs, model_flat());
        for (int k = 0; k < bdelay; k++) begin
            @(negedge clk);
            check_eq("wr_bvalid_hold", bus.bvalid, 1);
            check_eq("wr_bresp_hold", bus.bresp, exp_resp);
            check_eq("wr_ready_blocked", {bus.awready, bus.wready}, 2'b00);
            check_eq("wr_pulse_once", pulse, 0);
        end
        bus.bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.bready = 1'b0;
        check_eq("wr_bvalid_clear", bus.bvalid, 0);
        check_eq("wr_ready_back", {bus.awready, bus.wready}, 2'b11);
    endtask

    task automatic do_read(input logic [31:0] addr, input int rdelay);
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        @(negedge clk);
        bus.arvalid = 1'b1;
        bus.araddr  = addr;
        check_eq("rd_arready", bus.arready, 1);
        exp_data = model_read(addr);
        exp_resp = (classify(addr) == 2) ? 2'b11 : 2'b00;
        @(posedge clk);
        @(negedge clk);
        bus.arvalid = 1'b0;
        check_eq("rd_rvalid", bus.rvalid, 1);
        check_eq("rd_rdata", bus.rdata, exp_data);
        check_eq("rd_rresp", bus.rresp, exp_resp);
        for (int k = 0; k < rdelay; k++) begin
            stat_in = {$urandom, $urandom};
            @(negedge clk);
            check_eq("rd_rvalid_hold", bus.rvalid, 1);
            check_eq("rd_rdata_hold", bus.rdata, exp_data);
            check_eq("rd_arready_low", bus.arready, 0);
        end
        bus.rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rready = 1'b0;
        check_eq("rd_rvalid_clear", bus.rvalid, 0);
        check_eq("rd_arready_back", bus.arready, 1);
    endtask

    initial begin
        logic [31:0] old_val;
        logic [31:0] addr;
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        stat_in     = 64'h0;
        bus.awaddr  = '0;
        bus.awvalid = 1'b0;
        bus.wdata   = '0;
        bus.wstrb   = '0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b0;
        bus.araddr  = '0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;
        model_reset();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ready", {bus.awready, bus.wready, bus.arready}, 3'b000);
        check_eq("rst_valid", {bus.bvalid, bus.rvalid}, 2'b00);
        check_eq("rst_resp", {bus.bresp, bus.rresp}, 4'h0);
        check_eq("rst_rdata", bus.rdata, 0);
        check_eq("rst_ctrl", ctrl_regs, 0);
        check_eq("rst_pulse", pulse, 0);
        rst = 1'b0;

        do_write(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        do_write(32'h4, 32'h11223344, 4'h5, 3, 0, 5);
        check_eq("strobe_merge", ctrl_regs[63:32], 32'hDE22BE44);
        do_write(32'h10, 32'h12345678, 4'hF, 0, 0, 1);
        do_write(32'h18, 32'h12345678, 4'hF, 1, 0, 0);
        do_read(32'h18, 0);
        do_write(32'h8, 32'hFFFFFFFF, 4'h0, 0, 2, 0);

        stat_in = {32'hCAFE0001, 32'h0BAD0000};
        do_read(32'h14, 3);
        do_read(32'h10, 0);
        do_read(32'h4, 1);

        // Write to reg 0 commits on the same edge that accepts a read of reg 0.
        @(negedge clk);
        bus.awvalid = 1'b1;
        bus.awaddr  = 32'h0;
        bus.wvalid  = 1'b1;
        bus.wdata   = 32'h5A;
        bus.wstrb   = 4'hF;
        @(posedge clk);
        @(negedge clk);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.arvalid = 1'b1;
        bus.araddr  = 32'h0;
        old_val = model[0];
        @(posedge clk);
        @(negedge clk);
        bus.arvalid = 1'b0;
        model[0] = 32'h5A;
        check_eq("same_edge_rdata", bus.rdata, old_val);
        check_eq("same_edge_bvalid", bus.bvalid, 1);
        check_eq("same_edge_pulse", pulse, 4'b0001);
        check_eq("same_edge_ctrl", ctrl_regs, model_flat());
        bus.bready = 1'b1;
        bus.rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.bready = 1'b0;
        bus.rready = 1'b0;
        do_read(32'h0, 0);

        // Reset lands between AW acceptance and W; the orphaned address must never complete.
        @(negedge clk);
        bus.awvalid = 1'b1;
        bus.awaddr  = 32'h8;
        @(posedge clk);
        @(negedge clk);
        bus.awvalid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("mid_rst_ready", {bus.awready, bus.wready, bus.arready}, 3'b000);
        check_eq("mid_rst_ctrl", ctrl_regs, 0);
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("orphan_no_bvalid", bus.bvalid, 0);
        end
        do_write(32'hC, 32'hA5A5F00D, 4'hF, 0, 0, 0);
        check_eq("post_rst_regs", ctrl_regs, {32'hA5A5F00D, 96'h0});

        for (int n = 0; n < 60; n++) begin
            addr = 32'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) addr = $urandom;
            if ($urandom_range(0, 1) == 0) begin
                do_write(addr, $urandom, 4'($urandom_range(0, 15)),
                         $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            end else begin
                stat_in = {$urandom, $urandom};
                do_read(addr, $urandom_range(0, 3));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
